// File: rtl/user_io_pkg.sv
// Shared types and defaults for the user project I/O controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package user_io_pkg;

   // Controller sequencing states, from pad reset through to a terminal mode.
   typedef enum logic [2:0] {
      S_RST,
      S_SETTLE,
      S_STRAP,
      S_HOLD,
      S_RUN,
      S_LOOP,
      S_FAULT
   } state_t;

   localparam int SYNC_STAGES_DEF  = 2;
   localparam int SETTLE_CYC_DEF   = 8;
   localparam int RST_HOLD_CYC_DEF = 16;

   // Pattern driven on the uo pads for an invalid strap: only the MSB set,
   // so it is easy to spot on a scope and cannot be mistaken for idle.
   function automatic logic [63:0] fault_pattern(input int width);
      logic [63:0] p;
      p = '0;
      p[width-1] = 1'b1;
      return p;
   endfunction

endpackage

// File: rtl/user_io_sync.sv
// Multi-flop synchroniser for WIDTH independent bits, cleared by async active-low reset.
// Latency: STAGES clock edges from input to output.
// Backpressure: none; samples every cycle.
module user_io_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_q;

   // Shift the input through the synchroniser chain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else begin
         r_q[0] <= i_d;
         for (int s = 1; s < STAGES; s++) begin
            r_q[s] <= r_q[s-1];
         end
      end
   end

   assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/user_io_ctrl.sv
// Pad-side controller: synchronises reset/ui, latches a project strap, sequences and routes the selected project.
// Latency: pad->slot SYNC_STAGES cycles, slot->pad 1 cycle, loopback SYNC_STAGES+1 cycles.
// Backpressure: none; pure streaming pin routing.
module user_io_ctrl
   import user_io_pkg::*;
#(
   parameter int NUM_UI       = 17,
   parameter int NUM_UO       = 17,
   parameter int NUM_PROJ     = 4,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int SETTLE_CYC   = SETTLE_CYC_DEF,
   parameter int RST_HOLD_CYC = RST_HOLD_CYC_DEF,
   parameter int SEL_W        = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NUM_UI-1:0]          ui_PAD2CORE,
   output logic [NUM_UO-1:0]          uo_CORE2PAD,
   output logic [NUM_PROJ*NUM_UI-1:0] proj_ui_o,
   input  logic [NUM_PROJ*NUM_UO-1:0] proj_uo_i,
   output logic [NUM_PROJ-1:0]        proj_rst_no,
   output logic [SEL_W-1:0]           sel_o,
   output logic                       run_o,
   output logic                       loop_o,
   output logic                       fault_o
);

   localparam int CNT_MAX = (SETTLE_CYC > RST_HOLD_CYC) ? SETTLE_CYC : RST_HOLD_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [NUM_UO-1:0] FAULT_PATTERN = NUM_UO'(fault_pattern(NUM_UO));

   logic                       w_rst_sync_n;
   logic [NUM_UI-1:0]          w_ui_s;
   state_t                     r_state;
   state_t                     w_next;
   logic [CNT_W-1:0]           r_cnt;
   logic [CNT_W-1:0]           w_cnt_nxt;
   logic [SEL_W-1:0]           r_sel;
   logic [SEL_W-1:0]           w_sel_nxt;
   logic [SEL_W-1:0]           w_strap_sel;
   logic                       w_strap_lp;
   logic                       w_strap_valid;
   logic [NUM_PROJ-1:0]        w_sel_oh;
   logic                       w_route_in;
   logic [NUM_UO-1:0]          w_sel_uo;
   logic [NUM_PROJ*NUM_UI-1:0] w_proj_ui;
   logic [NUM_UO-1:0]          r_uo;
   logic [NUM_PROJ-1:0]        r_proj_rst_n;

   // Pad reset: asserts immediately, releases after SYNC_STAGES clean edges.
   user_io_sync #(
      .WIDTH  (1),
      .STAGES (SYNC_STAGES)
   ) u_rst_sync (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_d     (1'b1),
      .o_q     (w_rst_sync_n)
   );

   // ui pads are asynchronous to the core; every bit gets its own chain.
   user_io_sync #(
      .WIDTH  (NUM_UI),
      .STAGES (SYNC_STAGES)
   ) u_ui_sync (
      .i_clk   (clk_i),
      .i_rst_n (w_rst_sync_n),
      .i_d     (ui_PAD2CORE),
      .o_q     (w_ui_s)
   );

   assign w_strap_sel   = w_ui_s[SEL_W-1:0];
   assign w_strap_lp    = w_ui_s[SEL_W];
   assign w_strap_valid = ({1'b0, w_strap_sel} < (SEL_W+1)'(NUM_PROJ));

   // State, shared cycle counter and latched select.
   always_ff @(posedge clk_i or negedge w_rst_sync_n) begin
      if (!w_rst_sync_n) begin
         r_state <= S_RST;
         r_cnt   <= '0;
         r_sel   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   // Next-state sequencing. The settle window counts from the first cycle
   // out of internal reset, so the single S_RST cycle is part of it.
   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_sel_nxt = r_sel;
      case (r_state)
         S_RST: begin
            w_next    = S_SETTLE;
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
         S_SETTLE: begin
            if (r_cnt >= CNT_W'(SETTLE_CYC - 1)) begin
               w_next    = S_STRAP;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         S_STRAP: begin
            w_sel_nxt = w_strap_sel;
            w_cnt_nxt = '0;
            // Loopback wins even when the select field is out of range.
            if (w_strap_lp) begin
               w_next = S_LOOP;
            end else if (!w_strap_valid) begin
               w_next = S_FAULT;
            end else begin
               w_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (r_cnt == CNT_W'(RST_HOLD_CYC - 1)) begin
               w_next    = S_RUN;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            // S_RUN, S_LOOP and S_FAULT only leave through reset.
            w_next = r_state;
         end
      endcase
   end

   // One-hot of the latched select; empty when the select is out of range.
   always_comb begin
      w_sel_oh = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         w_sel_oh[k] = (r_sel == SEL_W'(k));
      end
   end

   // The selected project sees live pins while still held in reset.
   assign w_route_in = (r_state == S_HOLD) || (r_state == S_RUN);

   // Steer ui_s to the selected slot only; all other slots are isolated to 0.
   always_comb begin
      w_proj_ui = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (w_route_in && w_sel_oh[k]) begin
            w_proj_ui[k*NUM_UI +: NUM_UI] = w_ui_s;
         end
      end
   end

   // Pick the selected project's uo slot.
   always_comb begin
      w_sel_uo = '0;
      for (int k = 0; k < NUM_PROJ; k++) begin
         if (w_sel_oh[k]) begin
            w_sel_uo = proj_uo_i[k*NUM_UO +: NUM_UO];
         end
      end
   end

   // Registered pad outputs and per-slot resets; the release follows the
   // next state so proj_rst_no rises on the very edge that enters S_RUN.
   always_ff @(posedge clk_i or negedge w_rst_sync_n) begin
      if (!w_rst_sync_n) begin
         r_uo         <= '0;
         r_proj_rst_n <= '0;
      end else begin
         r_proj_rst_n <= (w_next == S_RUN) ? w_sel_oh : '0;
         case (r_state)
            S_RUN:   r_uo <= w_sel_uo;
            S_LOOP:  r_uo <= NUM_UO'(w_ui_s);
            S_FAULT: r_uo <= FAULT_PATTERN;
            default: r_uo <= '0;
         endcase
      end
   end

   assign uo_CORE2PAD = r_uo;
   assign proj_ui_o   = w_proj_ui;
   assign proj_rst_no = r_proj_rst_n;
   assign sel_o       = r_sel;
   assign run_o       = (r_state == S_RUN);
   assign loop_o      = (r_state == S_LOOP);
   assign fault_o     = (r_state == S_FAULT);

endmodule

// File: tb/tb_user_io_ctrl.sv
// Bench for user_io_ctrl: default 4-slot instance plus a 3-slot instance for the invalid-strap case.
// Latency: expectations derived from edge counts after pad reset release.
// Backpressure: n/a.
module tb_user_io_ctrl;

   localparam int NUI   = 17;
   localparam int NUO   = 17;
   localparam int SYNC  = 2;
   localparam int SETL  = 8;
   localparam int HOLD  = 16;
   // Edge (counted from rst_ni release) on which the selected project is released.
   localparam int REL_EDGE   = SYNC + SETL + 1 + HOLD;
   // Edge after which the latched select is guaranteed visible.
   localparam int LATCH_EDGE = SYNC + SETL + 1;

   logic              clk = 1'b0;
   logic              rst_ni;
   logic [NUI-1:0]    ui;

   logic [NUO-1:0]    uo_a;
   logic [4*NUI-1:0]  pui_a;
   logic [4*NUO-1:0]  puo_a;
   logic [3:0]        prst_a;
   logic [1:0]        sel_a;
   logic              run_a, loop_a, fault_a;

   logic [NUO-1:0]    uo_b;
   logic [3*NUI-1:0]  pui_b;
   logic [3*NUO-1:0]  puo_b;
   logic [2:0]        prst_b;
   logic [1:0]        sel_b;
   logic              run_b, loop_b, fault_b;

   int total = 0;
   int bad   = 0;

   logic [NUI-1:0]   ui_h  [0:63];
   logic [4*NUO-1:0] puo_h [0:63];

   user_io_ctrl u_dut_a (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .ui_PAD2CORE (ui),
      .uo_CORE2PAD (uo_a),
      .proj_ui_o   (pui_a),
      .proj_uo_i   (puo_a),
      .proj_rst_no (prst_a),
      .sel_o       (sel_a),
      .run_o       (run_a),
      .loop_o      (loop_a),
      .fault_o     (fault_a)
   );

   user_io_ctrl #(.NUM_PROJ(3)) u_dut_b (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .ui_PAD2CORE (ui),
      .uo_CORE2PAD (uo_b),
      .proj_ui_o   (pui_b),
      .proj_uo_i   (puo_b),
      .proj_rst_no (prst_b),
      .sel_o       (sel_b),
      .run_o       (run_b),
      .loop_o      (loop_b),
      .fault_o     (fault_b)
   );

   always #5 clk = ~clk;

   // Reference: expected per-slot reset vector for a given strap and edge number.
   function automatic logic [3:0] exp_rst(input int e, input logic [2:0] strap, input int nproj);
      int s;
      s = int'(strap[1:0]);
      if (strap[2] || s >= nproj || e < REL_EDGE) return 4'b0000;
      return 4'(1 << s);
   endfunction

   function automatic logic [NUI-1:0] rnd_ui();
      return NUI'($urandom);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the pads in reset with the strap applied, then release on a falling edge.
   task automatic apply_reset(input logic [NUI-1:0] strap);
      rst_ni = 1'b0;
      ui     = strap;
      step();
      step();
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      ui     = rnd_ui();
      puo_a  = {$urandom, $urandom, $urandom};
      puo_b  = 51'({$urandom, $urandom});
      repeat (3) step();
      total++; if (uo_a !== '0)   begin bad++; $display("FAIL reset_uo got %h want 0", uo_a); end
      total++; if (pui_a !== '0)  begin bad++; $display("FAIL reset_proj_ui got %h want 0", pui_a); end
      total++; if (prst_a !== '0) begin bad++; $display("FAIL reset_proj_rst got %b want 0", prst_a); end
      total++; if ({sel_a, run_a, loop_a, fault_a} !== '0)
         begin bad++; $display("FAIL reset_flags got %b want 0", {sel_a, run_a, loop_a, fault_a}); end
      total++; if ({uo_b, prst_b, fault_b} !== '0)
         begin bad++; $display("FAIL reset_b got %h want 0", {uo_b, prst_b, fault_b}); end
   endtask

   task automatic test_boot_sequence();
      for (int it = 0; it < 4; it++) begin
         logic [1:0]     s;
         logic [NUI-1:0] strap;
         s     = (it == 0) ? 2'd2 : 2'($urandom_range(0, 3));
         strap = (it == 0) ? 17'h00002 : ((rnd_ui() & ~17'h7) | NUI'(s));
         apply_reset(strap);
         for (int e = 1; e <= 30; e++) begin
            step();
            total++;
            if (prst_a !== exp_rst(e, strap[2:0], 4))
               begin bad++; $display("FAIL boot_rst e=%0d got %b want %b", e, prst_a, exp_rst(e, strap[2:0], 4)); end
            total++;
            if (run_a !== (e >= REL_EDGE))
               begin bad++; $display("FAIL boot_run e=%0d got %b want %b", e, run_a, (e >= REL_EDGE)); end
            if (e < LATCH_EDGE - 1) begin
               total++;
               if (sel_a !== 2'd0) begin bad++; $display("FAIL boot_sel_early e=%0d got %0d want 0", e, sel_a); end
            end else if (e >= LATCH_EDGE) begin
               total++;
               if (sel_a !== s) begin bad++; $display("FAIL boot_sel e=%0d got %0d want %0d", e, sel_a, s); end
            end
         end
      end
   endtask

   task automatic test_run_routing();
      for (int it = 0; it < 4; it++) begin
         int s;
         logic [4*NUI-1:0] exp_ui;
         s = (it == 0) ? 1 : $urandom_range(0, 3);
         apply_reset(NUI'(s));
         repeat (30) step();
         for (int i = 0; i < 40; i++) begin
            ui_h[i]  = (i < 4) ? 17'h00F0F : rnd_ui();
            puo_h[i] = (i == 0) ? {17'h1FFFF, 17'h1FFFF, 17'h1A5A5, 17'h1FFFF}
                                : 68'({$urandom, $urandom, $urandom});
            if (i == 0 && s != 1) puo_h[i][s*NUO +: NUO] = 17'h1A5A5;
            ui    = ui_h[i];
            puo_a = puo_h[i];
            step();
            total++;
            if (uo_a !== puo_h[i][s*NUO +: NUO])
               begin bad++; $display("FAIL run_uo i=%0d got %h want %h", i, uo_a, puo_h[i][s*NUO +: NUO]); end
            if (i >= 1) begin
               exp_ui = '0;
               exp_ui[s*NUI +: NUI] = ui_h[i-1];
               total++;
               if (pui_a !== exp_ui)
                  begin bad++; $display("FAIL run_proj_ui i=%0d got %h want %h", i, pui_a, exp_ui); end
            end
         end
      end
   endtask

   task automatic test_loopback();
      for (int it = 0; it < 3; it++) begin
         logic [NUI-1:0] strap;
         logic [NUI-1:0] exp_uo;
         strap = (it == 0) ? 17'h00004 : (rnd_ui() | 17'h00004);
         apply_reset(strap);
         repeat (30) step();
         total++; if (loop_a !== 1'b1) begin bad++; $display("FAIL loop_flag got %b want 1", loop_a); end
         total++; if ({run_a, fault_a} !== 2'b00) begin bad++; $display("FAIL loop_other got %b want 00", {run_a, fault_a}); end
         for (int i = 0; i < 30; i++) begin
            ui_h[i] = (i == 0) ? 17'h15555 : rnd_ui();
            ui      = ui_h[i];
            step();
            exp_uo = (i >= 2) ? ui_h[i-2] : strap;
            total++;
            if (uo_a !== exp_uo) begin bad++; $display("FAIL loop_uo i=%0d got %h want %h", i, uo_a, exp_uo); end
            total++;
            if (prst_a !== 4'b0000 || pui_a !== '0)
               begin bad++; $display("FAIL loop_iso i=%0d got %b/%h want 0/0", i, prst_a, pui_a); end
         end
      end
   endtask

   task automatic test_fault();
      apply_reset((rnd_ui() & ~17'h7) | 17'h3);
      repeat (30) step();
      for (int i = 0; i < 1000; i++) begin
         ui    = rnd_ui();
         puo_b = 51'({$urandom, $urandom});
         step();
         total++;
         if (fault_b !== 1'b1 || uo_b !== 17'h10000)
            begin bad++; $display("FAIL fault_state i=%0d got %b/%h want 1/10000", i, fault_b, uo_b); end
         total++;
         if (prst_b !== 3'b000 || {run_b, loop_b} !== 2'b00 || sel_b !== 2'd3)
            begin bad++; $display("FAIL fault_hold i=%0d got %b/%b/%0d want 000/00/3", i, prst_b, {run_b, loop_b}, sel_b); end
      end
   endtask

   task automatic test_async_reset();
      int s;
      s = $urandom_range(0, 3);
      apply_reset(NUI'(s));
      repeat (30) step();
      ui    = rnd_ui() | 17'h1;
      puo_a = {$urandom, $urandom, $urandom};
      puo_a[s*NUO] = 1'b1;
      step();
      step();
      total++; if (run_a !== 1'b1 || uo_a === '0)
         begin bad++; $display("FAIL arst_pre got %b/%h want 1/nonzero", run_a, uo_a); end
      #3;
      rst_ni = 1'b0;
      #1;
      total++; if (uo_a !== '0) begin bad++; $display("FAIL arst_uo got %h want 0", uo_a); end
      total++; if (prst_a !== '0 || run_a !== 1'b0)
         begin bad++; $display("FAIL arst_rst got %b/%b want 0/0", prst_a, run_a); end
      total++; if (pui_a !== '0 || sel_a !== '0)
         begin bad++; $display("FAIL arst_misc got %h/%0d want 0/0", pui_a, sel_a); end
      apply_reset(17'h00000);
      for (int e = 1; e <= 28; e++) begin
         step();
         total++;
         if (prst_a !== exp_rst(e, 3'b000, 4))
            begin bad++; $display("FAIL arst_rerel e=%0d got %b want %b", e, prst_a, exp_rst(e, 3'b000, 4)); end
      end
   endtask

   task automatic test_strap_lock();
      for (int it = 0; it < 2; it++) begin
         logic [1:0] s;
         s = (it == 0) ? 2'd2 : 2'($urandom_range(0, 3));
         apply_reset(NUI'(s));
         for (int e = 1; e <= LATCH_EDGE + 100; e++) begin
            step();
            if (e >= LATCH_EDGE) begin
               total++;
               if (sel_a !== s || loop_a !== 1'b0)
                  begin bad++; $display("FAIL lock_sel e=%0d got %0d/%b want %0d/0", e, sel_a, loop_a, s); end
               total++;
               if (prst_a !== exp_rst(e, {1'b0, s}, 4))
                  begin bad++; $display("FAIL lock_rst e=%0d got %b want %b", e, prst_a, exp_rst(e, {1'b0, s}, 4)); end
            end
            if (e == LATCH_EDGE) ui = (rnd_ui() & ~17'h7) | 17'h5;
         end
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      ui     = '0;
      puo_a  = '0;
      puo_b  = '0;
      test_reset();
      test_boot_sequence();
      test_run_routing();
      test_loopback();
      test_fault();
      test_async_reset();
      test_strap_lock();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
